// File: rtl/attribute_serializer.sv
// attribute_serializer: turns an attribute type code and unsigned value into the ASCII text "name=digits ", one char per handshake
// Ports: clock/reset (async, active high); start + in_type/in_value request a transaction (sampled only when idle);
// char/char_valid/char_ready is the output char handshake; busy covers the whole transaction;
// has_finished pulses once at the end, with error set when in_type was not a known code.
module attribute_serializer #(
  parameter int TYPE_W = 4,
  parameter int VAL_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [VAL_W-1:0]  in_value,
  input  logic              char_ready,
  output logic [7:0]        char,
  output logic              char_valid,
  output logic              busy,
  output logic              has_finished,
  output logic              error
);
  localparam int NUM_TYPES = 11;
  localparam int CW = $clog2(VAL_W + 1);
  typedef enum logic [2:0] {IDLE, CONVERT, NAME, EQUALS, DIGS, TERM, DONE} state_t;
  state_t                        state;
  logic [TYPE_W-1:0]             typ;
  logic [VAL_W-1:0]              bin;
  logic [4*DIGITS-1:0]           bcd, adj;
  logic [4*DIGITS+VAL_W-1:0]     dabble;
  logic [CW-1:0]                 cnt;
  logic [3:0]                    idx, msd, nlen;
  logic [127:0]                  nm;
  logic                          known_in;
  // Name ROM: string right-aligned in nm, first char at byte nlen-1; nlen==0 marks an unknown code
  always_comb begin
    nm = '0;
    nlen = '0;
    case (int'(typ))
      0: begin nm = 128'("color"); nlen = 4'd5; end
      1: begin nm = 128'("size"); nlen = 4'd4; end
      2: begin nm = 128'("width"); nlen = 4'd5; end
      3: begin nm = 128'("height"); nlen = 4'd6; end
      4: begin nm = 128'("src"); nlen = 4'd3; end
      5: begin nm = 128'("href"); nlen = 4'd4; end
      6: begin nm = 128'("background"); nlen = 4'd10; end
      7: begin nm = 128'("padding"); nlen = 4'd7; end
      8: begin nm = 128'("margin"); nlen = 4'd6; end
      9: begin nm = 128'("border"); nlen = 4'd6; end
      10: begin nm = 128'("position"); nlen = 4'd8; end
      default: begin nm = '0; nlen = '0; end
    endcase
  end
  // One double-dabble step (add 3 to nibbles >= 5, then shift) and the most significant nonzero digit
  always_comb begin
    adj = bcd;
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      if (|bcd[4*i +: 4]) msd = 4'(i);
    end
    dabble = {adj, bin} << 1;
  end
  assign known_in = int'(in_type) < NUM_TYPES;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      typ <= '0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      idx <= '0;
      char <= '0;
      char_valid <= 1'b0;
      busy <= 1'b0;
      has_finished <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          typ <= in_type;
          bin <= in_value;
          bcd <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= known_in ? CONVERT : DONE;
          has_finished <= !known_in;
          error <= !known_in;
        end
        // VAL_W shift steps, then one extra cycle to present the first name char
        CONVERT: if (cnt == CW'(VAL_W)) begin
          state <= NAME;
          idx <= '0;
          char <= nm[{nlen - 4'd1, 3'b000} +: 8];
          char_valid <= 1'b1;
        end else begin
          {bcd, bin} <= dabble;
          cnt <= cnt + 1'b1;
        end
        NAME: if (char_ready) begin
          if (idx == nlen - 4'd1) begin
            state <= EQUALS;
            char <= "=";
          end else begin
            idx <= idx + 1'b1;
            char <= nm[{nlen - 4'd2 - idx, 3'b000} +: 8];
          end
        end
        EQUALS: if (char_ready) begin
          state <= DIGS;
          idx <= msd;
          char <= {4'h3, bcd[{msd, 2'b00} +: 4]};
        end
        DIGS: if (char_ready) begin
          if (idx == 4'd0) begin
            state <= TERM;
            char <= " ";
          end else begin
            idx <= idx - 1'b1;
            char <= {4'h3, bcd[{idx - 4'd1, 2'b00} +: 4]};
          end
        end
        TERM: if (char_ready) begin
          state <= DONE;
          char_valid <= 1'b0;
          has_finished <= 1'b1;
          error <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          has_finished <= 1'b0;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
